// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller: edge-captured pending bits, mask/enable, vectored request.
// Optional input synchronizer enabled by defining INT_CTRL_SYNC_EN.
module int_ctrl #(
    parameter int unsigned N_SRC          = 4,
    parameter logic [7:0]  RESET_VEC_BASE = 8'hF0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             reg_w_en,
    input  logic [1:0]       reg_addr,
    input  logic [7:0]       reg_w_data,
    output logic [7:0]       reg_r_data,
    input  logic             int_done,
    output logic             int_req,
    output logic [7:0]       int_en,
    output logic [7:0]       int_vec
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    localparam logic [7:0] CtrlMask = 8'(((32'd1 << N_SRC) - 32'd1) << 4) | 8'h01;

    state_e             state_q, state_d;
    logic [7:0]         ctrl_q, ctrl_d;
    logic [7:0]         vbase_q, vbase_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   prev_q, prev_d;
    logic [N_SRC-1:0]   edge_q, edge_d;
    logic               in_svc_q, in_svc_d;
    logic [1:0]         act_id_q, act_id_d;
    logic               req_q, req_d;
    logic [7:0]         vec_q, vec_d;
    logic [N_SRC-1:0]   irq_in;
    logic [N_SRC-1:0]   elig;
    logic [1:0]         win_id;

`ifdef INT_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign irq_in = sync2_q;
`else
    assign irq_in = irq_src;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        vbase_d  = vbase_q;
        pend_d   = pend_q;
        in_svc_d = in_svc_q;
        act_id_d = act_id_q;
        req_d    = 1'b0;
        vec_d    = 8'h00;
        prev_d   = irq_in;
        edge_d   = irq_in & ~prev_q;

        elig   = pend_q & ctrl_q[4 +: N_SRC];
        win_id = 2'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win_id = 2'(i);
        end

        if (reg_w_en) begin
            case (reg_addr)
                2'd0:    ctrl_d  = reg_w_data & CtrlMask;
                2'd1:    pend_d  = pend_q & ~reg_w_data[N_SRC-1:0];
                2'd2:    vbase_d = reg_w_data;
                default: ;
            endcase
        end

        case (state_q)
            StIdle: begin
                if (ctrl_q[0] && (|elig)) begin
                    state_d  = StReq;
                    in_svc_d = 1'b1;
                    act_id_d = win_id;
                    req_d    = 1'b1;
                    vec_d    = vbase_q + {4'd0, win_id, 2'b00};
                end
            end
            StReq: begin
                state_d = StService;
                for (int i = 0; i < N_SRC; i++) begin
                    if (act_id_q == 2'(i)) pend_d[i] = 1'b0;
                end
            end
            StService: begin
                if (int_done) begin
                    state_d  = StIdle;
                    in_svc_d = 1'b0;
                    act_id_d = 2'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Applied last so a fresh edge beats both write-1-clear and service clear.
        pend_d = pend_d | edge_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            ctrl_q   <= 8'h00;
            vbase_q  <= RESET_VEC_BASE;
            pend_q   <= '0;
            prev_q   <= '0;
            edge_q   <= '0;
            in_svc_q <= 1'b0;
            act_id_q <= 2'd0;
            req_q    <= 1'b0;
            vec_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            vbase_q  <= vbase_d;
            pend_q   <= pend_d;
            prev_q   <= prev_d;
            edge_q   <= edge_d;
            in_svc_q <= in_svc_d;
            act_id_q <= act_id_d;
            req_q    <= req_d;
            vec_q    <= vec_d;
        end
    end

    always_comb begin
        reg_r_data = 8'h00;
        case (reg_addr)
            2'd0:    reg_r_data = ctrl_q;
            2'd1:    reg_r_data[N_SRC-1:0] = pend_q;
            2'd2:    reg_r_data = vbase_q;
            default: reg_r_data = {in_svc_q, 5'd0, act_id_q};
        endcase
    end

    assign int_req = req_q;
    assign int_vec = vec_q;
    assign int_en  = ctrl_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: expected vectors queued at stimulus time, popped at each int_req.
module tb_int_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] irq_src = 4'h0;
    logic       reg_w_en = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_w_data = 8'h00;
    logic [7:0] reg_r_data;
    logic       int_done = 1'b0;
    logic       int_req;
    logic [7:0] int_en;
    logic [7:0] int_vec;

`ifdef INT_CTRL_SYNC_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 2;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] vec_q[$];

    int_ctrl #(.N_SRC(4), .RESET_VEC_BASE(8'hF0)) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_src    (irq_src),
        .reg_w_en   (reg_w_en),
        .reg_addr   (reg_addr),
        .reg_w_data (reg_w_data),
        .reg_r_data (reg_r_data),
        .int_done   (int_done),
        .int_req    (int_req),
        .int_en     (int_en),
        .int_vec    (int_vec)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_w_en   = 1'b1;
        reg_addr   = a;
        reg_w_data = d;
        tick();
        reg_w_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
        reg_addr = a;
        @(negedge clock);
        chk(tag, {24'd0, reg_r_data}, {24'd0, exp});
    endtask

    task automatic pulse(input int idx);
        irq_src[idx] = 1'b1;
        tick();
        irq_src[idx] = 1'b0;
    endtask

    task automatic done_pulse();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    // Waits (bounded) for int_req, checks latency in negedges, pops the expected vector.
    task automatic wait_req(input string tag, input int exp_cyc);
        int cyc = 0;
        bit seen = 1'b0;
        logic [7:0] exp_vec;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clock);
            cyc  = i;
            seen = int_req;
        end
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            if (exp_cyc > 0) chk({tag, "_lat"}, cyc, exp_cyc);
            exp_vec = (vec_q.size() > 0) ? vec_q.pop_front() : 8'hxx;
            chk({tag, "_vec"}, {24'd0, int_vec}, {24'd0, exp_vec});
            @(negedge clock);
            chk({tag, "_one_cycle"}, {31'd0, int_req}, 32'd0);
            chk({tag, "_vec_idle"}, {24'd0, int_vec}, 32'd0);
        end
    endtask

    initial begin
        // Reset state held while reset is low
        repeat (3) @(negedge clock);
        chk("rst_req", {31'd0, int_req}, 32'd0);
        chk("rst_vec", {24'd0, int_vec}, 32'd0);
        chk("rst_en", {24'd0, int_en}, 32'd0);
        rd("rst_ctrl", 2'd0, 8'h00);
        rd("rst_pend", 2'd1, 8'h00);
        rd("rst_vbase", 2'd2, 8'hF0);
        rd("rst_active", 2'd3, 8'h00);
        reset = 1'b1;
        tick();

        // Basic request from src0
        wr(2'd0, 8'h11);
        wr(2'd2, 8'h40);
        chk("int_en", {24'd0, int_en}, 32'h11);
        vec_q.push_back(8'h40);
        pulse(0);
        wait_req("src0", Lat + 1);
        rd("src0_pend", 2'd1, 8'h00);
        rd("src0_active", 2'd3, 8'h80);
        done_pulse();
        rd("src0_active_done", 2'd3, 8'h00);

        // Simultaneous src1/src2: priority then second service
        wr(2'd0, 8'hF1);
        wr(2'd2, 8'h80);
        vec_q.push_back(8'h84);
        vec_q.push_back(8'h88);
        irq_src = 4'b0110;
        tick();
        irq_src = 4'b0000;
        wait_req("prio_first", Lat + 1);
        rd("prio_active1", 2'd3, 8'h81);
        rd("prio_pend1", 2'd1, 8'h04);
        done_pulse();
        wait_req("prio_second", 2);
        rd("prio_active2", 2'd3, 8'h82);
        done_pulse();

        // Vector wrap-around on src3
        wr(2'd2, 8'hFC);
        wr(2'd0, 8'h81);
        vec_q.push_back(8'h08);
        pulse(3);
        wait_req("wrap", Lat + 1);
        done_pulse();

        // Edge during SERVICE waits for int_done
        wr(2'd0, 8'hF1);
        wr(2'd2, 8'h20);
        vec_q.push_back(8'h24);
        pulse(1);
        wait_req("svc_first", Lat + 1);
        pulse(0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("svc_blocked", {31'd0, int_req}, 32'd0);
        end
        rd("svc_pend", 2'd1, 8'h01);
        vec_q.push_back(8'h20);
        done_pulse();
        wait_req("svc_after_done", 2);
        done_pulse();

        // Set beats write-1-clear in the same cycle
        wr(2'd0, 8'h00);
        irq_src[1] = 1'b1;
        repeat (Lat - 1) tick();
        wr(2'd1, 8'h02);
        irq_src[1] = 1'b0;
        rd("set_wins", 2'd1, 8'h02);
        wr(2'd1, 8'h02);
        rd("w1c", 2'd1, 8'h00);
        wr(2'd3, 8'hFF);
        rd("active_ro", 2'd3, 8'h00);

        // Reset mid-REQ drops int_req immediately
        wr(2'd0, 8'h11);
        wr(2'd2, 8'h40);
        pulse(0);
        repeat (Lat + 1) @(negedge clock);
        chk("midreq_req_hi", {31'd0, int_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midreq_req_drop", {31'd0, int_req}, 32'd0);
        chk("midreq_vec_drop", {24'd0, int_vec}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Reset mid-SERVICE discards state
        wr(2'd0, 8'h11);
        wr(2'd2, 8'h40);
        vec_q.push_back(8'h40);
        pulse(0);
        wait_req("pre_rst", Lat + 1);
        pulse(2);
        repeat (Lat) tick();
        rd("pre_rst_pend", 2'd1, 8'h04);
        reset = 1'b0;
        #1;
        chk("svcrst_req", {31'd0, int_req}, 32'd0);
        reg_addr = 2'd3;
        #1;
        chk("svcrst_active", {24'd0, reg_r_data}, 32'h00);
        reg_addr = 2'd1;
        #1;
        chk("svcrst_pend", {24'd0, reg_r_data}, 32'h00);
        reg_addr = 2'd2;
        #1;
        chk("svcrst_vbase", {24'd0, reg_r_data}, 32'hF0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Repeat of the basic request after reset
        wr(2'd0, 8'h11);
        wr(2'd2, 8'h40);
        vec_q.push_back(8'h40);
        pulse(0);
        wait_req("repeat", Lat + 1);
        rd("repeat_active", 2'd3, 8'h80);
        done_pulse();

        chk("queue_empty", vec_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
